// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard: tracks writes in flight from multi-cycle units,
// stalls issue on RAW/WAW hazards, and keeps occupancy and stall statistics.
module reg_scoreboard #(
  parameter int CNT_W = 16,
  parameter int OCC_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rs,
  input  logic [4:0]       iss_rt,
  input  logic             iss_use_rs,
  input  logic             iss_use_rt,
  input  logic             iss_wr,
  input  logic [4:0]       iss_rd,
  output logic             iss_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rn,
  input  logic             flush,
  output logic [31:0]      busy,
  output logic [OCC_W-1:0] occ,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      busy_q, busy_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic raw, waw, issue;
  logic set_en, clr_en;

  // Hazards look only at registered busy: a retiring write lands in the
  // register file at the end of this cycle, so its readers wait one cycle.
  always_comb begin
    raw       = (iss_use_rs & busy_q[iss_rs]) | (iss_use_rt & busy_q[iss_rt]);
    waw       = iss_wr & busy_q[iss_rd];
    iss_ready = ~(raw | waw);
    issue     = iss_valid & iss_ready;
    set_en    = issue & iss_wr & (iss_rd != 5'd0);
    clr_en    = wb_valid & (wb_rn != 5'd0);
  end

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[wb_rn]  = 1'b0;
    // Applied after the clear so a same-register set wins.
    if (set_en) busy_d[iss_rd] = 1'b1;
    if (flush)  busy_d         = '0;
    busy_d[0] = 1'b0;

    occ_d = '0;
    for (int i = 1; i < 32; i++) begin
      occ_d = occ_d + OCC_W'(busy_d[i]);
    end

    stall_cnt_d = stall_cnt_q;
    if (iss_valid && !iss_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their _d values together at the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      occ_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      occ_q       <= occ_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign occ       = occ_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (CNT_W=4 to reach saturation).
module tb_reg_scoreboard;

  localparam int CNT_W = 4;
  localparam int OCC_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             iss_valid, iss_use_rs, iss_use_rt, iss_wr;
  logic [4:0]       iss_rs, iss_rt, iss_rd, wb_rn;
  logic             iss_ready, wb_valid, flush;
  logic [31:0]      busy;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  reg_scoreboard #(.CNT_W(CNT_W), .OCC_W(OCC_W)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_use_rs(iss_use_rs), .iss_use_rt(iss_use_rt),
    .iss_wr(iss_wr), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_rn(wb_rn), .flush(flush),
    .busy(busy), .occ(occ), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are applied and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_use_rs = 0; iss_use_rt = 0; iss_wr = 0;
    iss_rs = 0; iss_rt = 0; iss_rd = 0;
    wb_valid = 0; wb_rn = 0; flush = 0;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    idle();
    iss_valid = 1; iss_wr = 1; iss_rd = rd;
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    // Reset with busy-looking inputs: reset overrides everything.
    iss_valid = 1; iss_wr = 1; iss_rd = 5'd8; wb_valid = 1; wb_rn = 5'd2;
    step();
    step();
    check("rst_busy", busy, 32'h0);
    check("rst_occ", 32'(occ), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    iss_use_rs = 1; iss_rs = 5'd17; iss_use_rt = 1; iss_rt = 5'd31; #1;
    check("rst_ready", 32'(iss_ready), 32'd1);
    rst = 0;

    // RAW stall and release.
    issue_wr(5'd5);
    check("raw_c0_ready", 32'(iss_ready), 32'd1);
    step();
    check("raw_busy5", busy, 32'h0000_0020);
    check("raw_occ1", 32'(occ), 32'd1);
    idle(); iss_valid = 1; iss_rs = 5'd5; iss_use_rs = 1; #1;
    check("raw_c1_ready", 32'(iss_ready), 32'd0);
    step();
    step();
    wb_valid = 1; wb_rn = 5'd5; #1;
    check("raw_c3_nobypass", 32'(iss_ready), 32'd0);
    step();
    check("raw_stall3", 32'(stall_cnt), 32'd3);
    check("raw_busy_clr", busy, 32'h0);
    wb_valid = 0; #1;
    check("raw_c4_ready", 32'(iss_ready), 32'd1);
    step();
    check("raw_stall_hold", 32'(stall_cnt), 32'd3);

    // WAW and $0.
    issue_wr(5'd7);
    step();
    issue_wr(5'd7);
    check("waw_ready", 32'(iss_ready), 32'd0);
    step();
    check("waw_stall4", 32'(stall_cnt), 32'd4);
    issue_wr(5'd0);
    check("rd0_ready", 32'(iss_ready), 32'd1);
    step();
    check("rd0_busy", busy, 32'h0000_0080);
    check("rd0_occ", 32'(occ), 32'd1);

    // Unused sources do not stall.
    issue_wr(5'd9);
    step();
    check("occ2", 32'(occ), 32'd2);
    idle(); iss_valid = 1; iss_rt = 5'd9; iss_use_rt = 0; iss_rs = 5'd7; #1;
    check("unused_ready", 32'(iss_ready), 32'd1);
    iss_valid = 0; iss_use_rt = 1; #1;
    check("used_rt_ready", 32'(iss_ready), 32'd0);

    // wb to $0 and to a non-busy register are no-ops.
    idle(); wb_valid = 1; wb_rn = 5'd0;
    step();
    wb_rn = 5'd8;
    step();
    check("wb_noop_busy", busy, 32'h0000_0280);

    // Flush with a simultaneous issue and write-back.
    idle(); flush = 1;
    step();
    check("flush0_busy", busy, 32'h0);
    issue_wr(5'd3);  step();
    issue_wr(5'd4);  step();
    issue_wr(5'd12); step();
    check("pre_flush_busy", busy, 32'h0000_1018);
    check("pre_flush_occ", 32'(occ), 32'd3);
    issue_wr(5'd20); flush = 1; wb_valid = 1; wb_rn = 5'd3; #1;
    check("flush_issue_ready", 32'(iss_ready), 32'd1);
    step();
    check("flush_busy", busy, 32'h0);
    check("flush_occ", 32'(occ), 32'd0);
    check("flush_stall", 32'(stall_cnt), 32'd4);

    // Saturation: 20 stalled cycles from 4 must stop at 15.
    issue_wr(5'd10);
    step();
    idle(); iss_valid = 1; iss_rs = 5'd10; iss_use_rs = 1;
    for (int i = 0; i < 20; i++) step();
    check("stall_sat", 32'(stall_cnt), 32'd15);

    // Reset mid-operation drops busy[10]; late wb is ignored.
    idle(); rst = 1;
    step();
    rst = 0;
    check("midrst_stall", 32'(stall_cnt), 32'd0);
    wb_valid = 1; wb_rn = 5'd10;
    step();
    check("midrst_busy", busy, 32'h0);

    // Set-wins: wb of r6 collides with a new issue to r6.
    issue_wr(5'd6); wb_valid = 1; wb_rn = 5'd6; #1;
    check("setwin_ready", 32'(iss_ready), 32'd1);
    step();
    check("setwin_busy", busy, 32'h0000_0040);
    check("setwin_occ", 32'(occ), 32'd1);

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-side hazard scheduler for the 32x32 register file (two combinational read ports, one posedge write port, $0 hard-wired zero).
- Tracks which registers have a write in flight from multi-cycle units. Stalls instruction issue on RAW (rs/rt pending) and WAW (rd pending) hazards.
- Clears pending state when the write-back port retires the write.
- Sits between decode/issue and the register-file write-back mux; also keeps occupancy and stall statistics.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.
- OCC_W, 6, width of the outstanding-write counter; must hold 0..31.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- iss_valid  input  1  decode presents an instruction this cycle.
- iss_rs  input  5  first source register number (read port 1).
- iss_rt  input  5  second source register number (read port 2).
- iss_use_rs  input  1  instruction actually reads rs.
- iss_use_rt  input  1  instruction actually reads rt.
- iss_wr  input  1  instruction will write a register via a multi-cycle unit.
- iss_rd  input  5  destination register number.
- iss_ready  output  1  no hazard; instruction issues this cycle when iss_valid=1.
- wb_valid  input  1  write-back retiring this cycle (same cycle RegWrite is asserted to the register file).
- wb_rn  input  5  register being written (the register file's WN).
- flush  input  1  discard all in-flight writes (e.g. exception).
- busy  output  32  pending-write vector; bit 0 always 0.
- occ  output  OCC_W  number of set busy bits.
- stall_cnt  output  CNT_W  cycles with iss_valid=1 and iss_ready=0, saturating.

Behaviour:
Reset:
- rst=1 at posedge clears busy, occ and stall_cnt to 0.
- rst overrides every other input that cycle.
- Reset mid-operation drops all pending state; later wb_valid to a non-busy register is ignored.

Hazard (combinational from registered busy only; no same-cycle bypass):
- raw = (iss_use_rs & busy[iss_rs]) | (iss_use_rt & busy[iss_rt]).
- waw = iss_wr & busy[iss_rd].
- iss_ready = ~(raw | waw). It is independent of iss_valid, wb_valid and flush.
- Rationale for no bypass: a wb retiring register R in cycle N updates the register file at the end of cycle N. A reader of R in cycle N would get the stale value, so it stalls one cycle and issues in N+1.

Issue:
- issue = iss_valid & iss_ready.
- If issue & iss_wr & (iss_rd != 0), busy[iss_rd] is set at the next posedge.
- iss_rd = 0 never sets a bit; such an instruction never stalls on WAW.

Write-back:
- wb_valid & (wb_rn != 0) clears busy[wb_rn] at the next posedge.
- wb to a non-busy register is a no-op.

Simultaneous events:
- Set and clear of the same register in one cycle: set wins (bit stays 1).
- This occurs only after a flush-or-reset race, since WAW blocks a new set while the bit is busy.
- flush=1: all busy bits and occ are 0 next cycle. An issue and wb in the same cycle are discarded; flush wins.
- stall_cnt is not affected by flush.

Counters:
- occ is the registered popcount of the next busy state, valid the same cycle busy is. occ ranges 0..31 and has no wrap.
- stall_cnt increments by 1 each posedge where iss_valid & ~iss_ready; it holds at 2^CNT_W-1.

Latency:
- busy/occ update 1 cycle after issue or wb.
- iss_ready reflects new busy state in the following cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> busy=0, occ=0, stall_cnt=0, iss_ready=1 for any inputs.
- RAW stall and release: issue iss_wr=1, iss_rd=5 in cycle 0; cycle 1 present iss_rs=5, iss_use_rs=1 -> iss_ready=0. wb_valid=1, wb_rn=5 in cycle 3 -> iss_ready=0 in cycle 3, 1 in cycle 4; stall_cnt=3 after cycle 3.
- WAW and $0: issue write to rd=7, then iss_wr=1, iss_rd=7 -> iss_ready=0. Then iss_wr=1, iss_rd=0 -> iss_ready=1, busy[0] stays 0, occ unchanged.
- Unused sources: busy[9]=1 with iss_rt=9, iss_use_rt=0 -> iss_ready=1.
- Flush with collision: busy={3,4,12}, occ=3. Same cycle flush=1, an issuing write to rd=20 and wb_rn=3 -> next cycle busy=0, occ=0.
- Saturation and set-wins: with CNT_W=4, hold a stalled iss_valid for 20 cycles -> stall_cnt=15. In a cycle where wb_rn=6 retires and an issuing write to rd=6 occurs (after reset cleared busy[6]) -> busy[6]=1 next cycle.
